// File: rtl/clock_divider_ctrl.sv
// Runtime-programmable clock divider: `out_o` toggles every div cycles, and ratio
// and run/stop changes are applied only at half-period boundaries.
module clock_divider_ctrl #(
    parameter int BITS        = 8,
    parameter int DEFAULT_DIV = 16,
    parameter bit START_EN    = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cfg_valid_i,
    output logic            cfg_ready_o,
    input  logic [BITS-1:0] cfg_div_i,
    input  logic            cfg_en_i,
    output logic            out_o,
    output logic            tick_o,
    output logic            busy_o,
    output logic            err_o,
    output logic [1:0]      state_o
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [BITS-1:0] ONE  = BITS'(1);
    localparam logic [BITS-1:0] ZERO = '0;

    logic [1:0]      state_q, state_d;
    logic [BITS-1:0] count_q, count_d;
    logic [BITS-1:0] div_q, div_d;
    logic [BITS-1:0] pdiv_q, pdiv_d;
    logic            pen_q, pen_d;
    logic            out_q, out_d;
    logic            tick_q;
    logic            err_q, err_d;

    logic xfer;
    logic term;

    // Handshake: a transfer occurs on a rising edge where cfg_valid_i and cfg_ready_o are both high.
    assign cfg_ready_o = (state_q != ST_PEND);
    assign xfer        = cfg_valid_i && cfg_ready_o;
    assign term        = (count_q == div_q - ONE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        pdiv_d  = pdiv_q;
        pen_d   = pen_q;
        out_d   = out_q;
        err_d   = err_q;

        if (state_q != ST_OFF) begin
            if (!term) begin
                count_d = count_q + ONE;
            end else begin
                count_d = ZERO;
                if (state_q == ST_RUN) begin
                    out_d = !out_q;
                end else if (pen_q) begin
                    out_d   = !out_q;
                    div_d   = pdiv_q;
                    state_d = ST_RUN;
                end else if (out_q) begin
                    out_d   = 1'b0;
                    state_d = ST_OFF;
                end else begin
                    // Stop requested during a low phase: emit one full high phase first.
                    out_d = 1'b1;
                end
            end
        end

        if (xfer) begin
            if (cfg_div_i == ZERO) begin
                err_d = 1'b1;
            end else if (state_q == ST_OFF) begin
                div_d = cfg_div_i;
                if (cfg_en_i) begin
                    count_d = ZERO;
                    state_d = ST_RUN;
                end
            end else begin
                pdiv_d  = cfg_div_i;
                pen_d   = cfg_en_i;
                state_d = ST_PEND;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= START_EN ? ST_RUN : ST_OFF;
            count_q <= ZERO;
            div_q   <= BITS'(DEFAULT_DIV);
            pdiv_q  <= ZERO;
            pen_q   <= 1'b0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            pen_q   <= pen_d;
            out_q   <= out_d;
            tick_q  <= (out_d != out_q);
            err_q   <= err_d;
        end
    end

    assign out_o   = out_q;
    assign tick_o  = tick_q;
    assign busy_o  = (state_q != ST_OFF);
    assign err_o   = err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Randomized and directed bench for clock_divider_ctrl, compared every cycle against
// a phase-length reference model.
module tb_clock_divider_ctrl;

  localparam int BITS        = 8;
  localparam int DEFAULT_DIV = 16;
  localparam bit START_EN    = 1'b1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            cfg_valid_i = 1'b0;
  logic            cfg_ready_o;
  logic [BITS-1:0] cfg_div_i = '0;
  logic            cfg_en_i = 1'b0;
  logic            out_o;
  logic            tick_o;
  logic            busy_o;
  logic            err_o;
  logic [1:0]      state_o;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Scoreboard vector: {out, tick, busy, cfg_ready, err}
  logic [4:0] exp_q[$];

  // Reference model: remaining cycles of the current phase, not an up-counter.
  logic m_out, m_tick, m_run, m_err, m_pend, m_pen;
  int   m_rem, m_half, m_pdiv;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  clock_divider_ctrl #(
    .BITS(BITS),
    .DEFAULT_DIV(DEFAULT_DIV),
    .START_EN(START_EN)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_div_i(cfg_div_i),
    .cfg_en_i(cfg_en_i),
    .out_o(out_o),
    .tick_o(tick_o),
    .busy_o(busy_o),
    .err_o(err_o),
    .state_o(state_o)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s t=%0t got {out,tick,busy,ready,err}=%b expected %b",
               phase, tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_edge(input logic r, input logic v, input int d, input logic e);
    logic prev_out, ready, was_run;
    if (r) begin
      m_out = 1'b0; m_tick = 1'b0; m_err = 1'b0;
      m_run = START_EN; m_rem = DEFAULT_DIV; m_half = DEFAULT_DIV;
      m_pend = 1'b0; m_pen = 1'b0; m_pdiv = 0;
    end else begin
      prev_out = m_out;
      ready    = !m_pend;
      was_run  = m_run;
      if (m_run) begin
        if (m_rem == 1) begin
          if (!m_pend) begin
            m_out = !m_out; m_rem = m_half;
          end else if (m_pen) begin
            m_out = !m_out; m_half = m_pdiv; m_rem = m_pdiv; m_pend = 1'b0;
          end else if (m_out) begin
            m_out = 1'b0; m_run = 1'b0; m_pend = 1'b0;
          end else begin
            m_out = 1'b1; m_rem = m_half;
          end
        end else begin
          m_rem--;
        end
      end
      if (v && ready) begin
        if (d == 0) begin
          m_err = 1'b1;
        end else if (!was_run) begin
          m_half = d;
          if (e) begin
            m_run = 1'b1; m_rem = d;
          end
        end else begin
          m_pend = 1'b1; m_pdiv = d; m_pen = e;
        end
      end
      m_tick = (m_out != prev_out);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input int d, input logic e);
    rst_i       = r;
    cfg_valid_i = v;
    cfg_div_i   = BITS'(d);
    cfg_en_i    = e;
    @(posedge clk_i);
    model_edge(r, v, d, e);
    exp_q.push_back({m_out, m_tick, m_run, !m_pend, m_err});
    #1;
    check_eq("outs", {out_o, tick_o, busy_o, cfg_ready_o, err_o}, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    phase = "reset_run16";
    do_reset();
    idle(70);

    phase = "reconfig_16_to_4";
    do_reset();
    idle(5);
    step(1'b0, 1'b1, 4, 1'b1);
    idle(40);

    phase = "stop_from_low";
    guard = 0;
    while (m_out != 1'b0 && guard < 20) begin
      idle(1);
      guard++;
    end
    step(1'b0, 1'b1, 4, 1'b0);
    idle(25);

    phase = "off_start_div1";
    step(1'b0, 1'b1, 1, 1'b1);
    idle(10);

    phase = "illegal_div0";
    idle(3);
    step(1'b0, 1'b1, 0, 1'b1);
    idle(10);

    phase = "coincident_tc_then_reset";
    do_reset();
    idle(15);
    step(1'b0, 1'b1, 3, 1'b1);
    idle(1);
    do_reset();
    idle(40);

    phase = "start_stopped_by_default_off_cfg";
    step(1'b0, 1'b1, 2, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 5, 1'b0);
    idle(30);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(1'b1, 1'b0, 0, 1'b0);
      end else if ($urandom_range(0, 9) == 0) begin
        int d;
        d = ($urandom_range(0, 19) == 0) ? 0 :
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 255)) % 40 + 1 :
            int'($urandom_range(1, 6));
        step(1'b0, 1'b1, d, ($urandom_range(0, 3) != 0));
      end else begin
        step(1'b0, 1'b0, int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_ctrl.md
# clock_divider_ctrl

Runtime-programmable clock divider with a configuration handshake. Software or an upstream sequencer changes the divide ratio or stops/starts the output. Changes are applied only at half-period boundaries, so `out` never shows a truncated high or low phase. It replaces the fixed-parameter divider wherever the ratio must change at run time, and keeps the same half-period semantics: `out` toggles every `div` input cycles.

## Interface
- `BITS`, 8: width of the divide value and the internal counter.
- `DEFAULT_DIV`, 16: half-period loaded at reset; must be in 1..2^BITS-1.
- `START_EN`, 1: 1 means the block leaves reset running at `DEFAULT_DIV`; 0 means it leaves reset stopped.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  a configuration request is presented.
- `cfg_ready`  out  1  the block can accept a configuration this cycle.
- `cfg_div`  in  BITS  requested half-period in `clk` cycles; 0 is illegal.
- `cfg_en`  in  1  1 means run at `cfg_div`; 0 means stop after the current high phase.
- `out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse, high in every cycle in which `out` has just changed value.
- `busy`  out  1  high when the state is not OFF.
- `err`  out  1  sticky flag: an illegal configuration was received; cleared only by `rst`.

## Operation
- States: OFF, RUN, PEND.
  - OFF: counter held at 0, `out`=0.
  - RUN: counter counts 0..`div`-1.
  - PEND: same as RUN, with one accepted configuration (`pdiv`, `pen`) waiting to be applied.
- Handshake: a transfer happens when `cfg_valid` and `cfg_ready` are both high on a rising edge.
  - `cfg_ready` = 1 in OFF and RUN, 0 in PEND.
  - `cfg_div`/`cfg_en` are sampled only on a transfer.
- Illegal configuration (`cfg_div`=0): the transfer completes but the request is discarded. `err` is set on the next edge and the state is unchanged.
- Transfers in OFF:
  - `cfg_en`=1: load `div`=`cfg_div`, counter=0, go to RUN.
  - `cfg_en`=0: load `div` only, stay in OFF.
- Transfer in RUN: store the request in `pdiv`/`pen`, go to PEND. This also applies when the transfer coincides with a terminal count: that terminal count uses the old `div`, and the request waits for the next terminal count.
- Terminal count is `count == div-1`:
  - RUN: counter goes to 0 and `out` toggles.
  - PEND with `pen`=1: counter goes to 0, `out` toggles, `div` becomes `pdiv`, go to RUN.
  - PEND with `pen`=0 and `out`=1: `out` goes to 0, counter goes to 0, go to OFF.
  - PEND with `pen`=0 and `out`=0: `out` toggles to 1 and the state stays PEND. The following high phase runs at full width, then the block stops on the next terminal count.
- `div`=1 gives `out` toggling every cycle, i.e. `clk`/2.
- Counter arithmetic is BITS wide and never wraps, because `div` ≤ 2^BITS-1.

## Timing
- Reset values:
  - `out`=0, `tick`=0, `err`=0.
  - Counter=0, `div`=`DEFAULT_DIV`, `pdiv`/`pen` cleared.
  - State = RUN if `START_EN`, else OFF, so `busy`=`START_EN` and `cfg_ready`=1.
- Reset during PEND or RUN discards any pending request. There is no partial phase after reset: `out` is 0 in the first cycle after reset.
- Run timing with half-period D:
  - The first toggle of `out` follows the D-th rising edge after entry to RUN. Entry to RUN is reset release, or the transfer edge when starting from OFF.
  - `out` then toggles every D cycles; the period is 2D.
- `tick` is registered alongside `out`. It is high exactly in the cycles following a toggle edge, including the final fall on entry to OFF.
- A reconfiguration takes effect at the next terminal count after the transfer edge. The first phase at the new ratio is exactly `pdiv` cycles long.
- Stop latency: at most 2D cycles from the transfer to `out` reaching 0. `busy` falls on the same edge that `out` falls.
- `cfg_ready` deasserts on the edge after a RUN transfer and reasserts on the edge that applies the pending request.

## Test plan
- Reset with `START_EN`=1, `DEFAULT_DIV`=16, no config -> `out`=0 for 16 cycles, then toggles every 16 cycles; `tick` pulses 16 cycles apart; `busy`=1, `err`=0.
- Running at 16, transfer `cfg_div`=4, `cfg_en`=1 at count 5 -> `cfg_ready`=0 until the next terminal count; current phase completes at 16 cycles; all subsequent phases are exactly 4 cycles.
- Running at 4, transfer `cfg_en`=0 while `out`=0 -> `out` rises, holds high for 4 cycles, falls to 0; `busy`=0 and `cfg_ready`=1 from that edge; `out` stays 0 thereafter.
- In OFF, transfer `cfg_div`=1, `cfg_en`=1 -> `out` toggles every cycle starting 1 cycle after the transfer edge; `tick` is high continuously.
- In RUN, transfer `cfg_div`=0 -> `err`=1 next cycle and stays 1; `out` timing unchanged; `cfg_ready` stays 1.
- Transfer in the same cycle as a terminal count, then assert `rst` 2 cycles later -> the old ratio is used for the coincident toggle; after reset `out`=0, `err`=0, `div`=16, and the pending request is never applied.
